// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: active-low segment patterns,
// scan FSM state encoding and a width helper.
package sevenseg_scan_ctrl_pkg;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_hex_ca.sv
// Combinational digit-to-segment decoder for common-anode displays; 0 cycles.
// Codes 10..15 and the blank input both produce an all-off pattern.
module sevenseg_hex_ca
    import sevenseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode scan controller with per-slot dead-time,
// frame-synchronous value update and leading-zero blanking; an_n/seg_n lag state by 1 cycle.
module sevenseg_scan_ctrl
    import sevenseg_scan_ctrl_pkg::*;
#(
    parameter  int N_DIGITS    = 4,
    parameter  int REFRESH_DIV = 50000,
    parameter  int DEAD_CYC    = 500,
    localparam int IDX_W       = clog2(N_DIGITS),
    localparam int CNT_W       = clog2(REFRESH_DIV)
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [6:0]              seg_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    scan_state_t             state_q, state_d;
    logic [4*N_DIGITS-1:0]   shadow_q, active_q;
    logic                    pending_q;

    logic                    slot_end, wrap;
    logic [3:0]              nib [N_DIGITS];
    logic [N_DIGITS-1:0]     lz_blank;
    logic                    zero_run;
    logic                    dec_blank;
    logic [6:0]              dec_seg;
    logic [N_DIGITS-1:0]     an_d;

    assign slot_end   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign wrap       = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
    assign frame_tick = wrap;
    assign digit_idx  = idx_q;

    // State tracks the slot counter: DEAD for the first DEAD_CYC counts of every slot.
    always_comb begin
        state_d = ST_DEAD;
        if (!slot_end && cnt_q >= CNT_W'(DEAD_CYC - 1)) state_d = ST_SHOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_DEAD;
        end else begin
            state_q <= state_d;
            if (slot_end) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // active only changes on the wrap edge, so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (load) shadow_q <= value;
            if (wrap) begin
                pending_q <= 1'b0;
                if (load)           active_q <= value;
                else if (pending_q) active_q <= shadow_q;
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_DIGITS; k++) nib[k] = active_q[4*k +: 4];
    end

    // Digit k is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run & (active_q[4*k +: 4] == 4'h0);
            lz_blank[k] = lz_en & zero_run;
        end
    end

    assign dec_blank = (state_q == ST_DEAD) | lz_blank[idx_q];

    sevenseg_hex_ca u_dec (
        .digit (nib[idx_q]),
        .blank (dec_blank),
        .seg_n (dec_seg)
    );

    always_comb begin
        an_d = '1;
        if (!dec_blank) an_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
        end else begin
            an_n  <= an_d;
            seg_n <= dec_seg;
        end
    end

endmodule
